// File: rtl/padctl_cfg_loader.sv
// Serial pad-attribute chain loader: shifts a parallel config word MSB-first on a divided sck, then strobes latch.
// Optional macro PADCTL_CFG_READBACK_EN adds chain readback and the mismatch_o flag.
module padctl_cfg_loader #(
    parameter int NumPads = 16,
    parameter int AttrW   = 4,
    parameter int ClkDiv  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [NumPads*AttrW-1:0]   cfg_i,
    output logic                       gnt_o,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic                       pad_cfg_sck_o,
    output logic                       pad_cfg_sdo_o,
    output logic                       pad_cfg_latch_o,
    input  logic                       pad_cfg_sdi_i,
    output logic                       mismatch_o
);

    localparam int NBits = NumPads * AttrW;
    localparam int PhW   = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int BitW  = (NBits > 1) ? $clog2(NBits) : 1;
    localparam logic [PhW-1:0]  PhLast = PhW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitTop = BitW'(NBits - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    state_t            state, state_nxt;
    logic [NBits-1:0]  shadow;
    logic [PhW-1:0]    phase_cnt;
    logic              sck_hi;
    logic [BitW-1:0]   bit_cnt;
    logic              aborted_q;
    logic              phase_end;
    logic              abort_hit;

    assign phase_end = (phase_cnt == PhLast);
    assign abort_hit = abort_i && (state == SHIFT || state == LATCH);
    assign gnt_o     = req_i && (state == IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (gnt_o) state_nxt = SHIFT;
            SHIFT: begin
                if (abort_i)                                        state_nxt = IDLE;
                else if (phase_end && sck_hi && bit_cnt == '0)      state_nxt = LATCH;
            end
            LATCH: begin
                if (abort_i)        state_nxt = IDLE;
                else if (phase_end) state_nxt = DONE;
            end
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: the shadow word is cleared on reset too, so sdo is never driven from unknown data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow    <= '0;
            phase_cnt <= '0;
            sck_hi    <= 1'b0;
            bit_cnt   <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
            case (state)
                IDLE: begin
                    if (gnt_o) begin
                        shadow    <= cfg_i;
                        bit_cnt   <= BitTop;
                        phase_cnt <= '0;
                        sck_hi    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        phase_cnt <= '0;
                        sck_hi    <= 1'b0;
                    end else if (phase_end) begin
                        phase_cnt <= '0;
                        sck_hi    <= ~sck_hi;
                        // sck falling edge: move to the next lower bit, holding at 0
                        if (sck_hi && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (abort_i || phase_end) phase_cnt <= '0;
                    else                      phase_cnt <= phase_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o          = 1'b0;
        done_o          = 1'b0;
        pad_cfg_sck_o   = 1'b0;
        pad_cfg_sdo_o   = 1'b0;
        pad_cfg_latch_o = 1'b0;
        case (state)
            SHIFT: begin
                busy_o        = 1'b1;
                pad_cfg_sck_o = sck_hi;
                pad_cfg_sdo_o = shadow[bit_cnt];
            end
            LATCH: begin
                busy_o          = 1'b1;
                pad_cfg_latch_o = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign aborted_o = aborted_q;

`ifdef PADCTL_CFG_READBACK_EN
    logic [NBits-1:0] ret_q;
    logic [NBits-1:0] last_cfg;
    logic             mismatch_q;

    // The chain is NBits long, so a full shift returns the previously latched word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ret_q      <= '0;
            last_cfg   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (state == SHIFT && !abort_i && phase_end && !sck_hi)
                ret_q <= {ret_q[NBits-2:0], pad_cfg_sdi_i};
            if (gnt_o) begin
                mismatch_q <= 1'b0;
            end else if (state == LATCH && !abort_i && phase_end) begin
                mismatch_q <= (ret_q != last_cfg);
                last_cfg   <= shadow;
            end
        end
    end

    assign mismatch_o = mismatch_q;
`else
    logic unused_sdi;
    assign unused_sdi = pad_cfg_sdi_i;
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_padctl_cfg_loader.sv
// Randomized self-checking bench for padctl_cfg_loader with a word-level model of the chain and a loopback pad chain.
// Readback expectations are enabled when PADCTL_CFG_READBACK_EN is defined.
module tb_padctl_cfg_loader;

    localparam int NBITS = 64;
    localparam int DIV   = 4;
    localparam int LAT   = 1 + NBITS * 2 * DIV + DIV;
    localparam int SLAT  = 1 + 4 * 2 * 1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req = 1'b0, abort = 1'b0;
    logic [NBITS-1:0]  cfg = '0;
    logic              gnt, busy, done, aborted, sck, sdo, latch, sdi, mismatch;

    logic              req_s = 1'b0;
    logic [3:0]        cfg_s = '0;
    logic              gnt_s, busy_s, done_s, aborted_s, sck_s, sdo_s, latch_s, mismatch_s;

    padctl_cfg_loader u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .cfg_i(cfg), .gnt_o(gnt),
        .abort_i(abort), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .pad_cfg_sck_o(sck), .pad_cfg_sdo_o(sdo), .pad_cfg_latch_o(latch),
        .pad_cfg_sdi_i(sdi), .mismatch_o(mismatch)
    );

    padctl_cfg_loader #(.NumPads(2), .AttrW(2), .ClkDiv(1)) u_small (
        .clk_i(clk), .rst_i(rst), .req_i(req_s), .cfg_i(cfg_s), .gnt_o(gnt_s),
        .abort_i(1'b0), .busy_o(busy_s), .done_o(done_s), .aborted_o(aborted_s),
        .pad_cfg_sck_o(sck_s), .pad_cfg_sdo_o(sdo_s), .pad_cfg_latch_o(latch_s),
        .pad_cfg_sdi_i(1'b0), .mismatch_o(mismatch_s)
    );

    // Loopback pad chain: shifts sdo on each sck rise; flip corrupts the returned bit.
    logic [NBITS-1:0] chain = '0;
    logic             flip  = 1'b0;
    always @(posedge sck) chain <= {chain[NBITS-2:0], sdo};
    assign sdi = chain[NBITS-1] ^ flip;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed-behaviour monitor, updated once per cycle on the falling edge.
    logic [NBITS-1:0] rise_bits;
    int rises, latch_cycles, dones, aborts, sdo_viol;
    logic prev_sck = 1'b0, prev_sdo = 1'b0;
    logic [3:0] bits_s = '0;
    int rises_s = 0, dones_s = 0, viol_s = 0, shift_s = 0;
    logic prev_sck_s = 1'b0;
    logic [NBITS-1:0] last_word = '0;

    task automatic clear_mon();
        rise_bits = '0; rises = 0; latch_cycles = 0; dones = 0; aborts = 0; sdo_viol = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (sck && !prev_sck) begin
            rise_bits = {rise_bits[NBITS-2:0], sdo};
            rises++;
            if (sdo !== prev_sdo) sdo_viol++;
        end
        if (sck && prev_sck && sdo !== prev_sdo) sdo_viol++;
        if (latch)   latch_cycles++;
        if (done)    dones++;
        if (aborted) aborts++;
        prev_sck = sck;
        prev_sdo = sdo;
        if (sck_s && !prev_sck_s) begin
            bits_s = {bits_s[2:0], sdo_s};
            rises_s++;
        end
        if (busy_s && !latch_s) begin
            if (shift_s > 0 && sck_s === prev_sck_s) viol_s++;
            shift_s++;
        end
        if (done_s) dones_s++;
        prev_sck_s = sck_s;
    endtask

    task automatic start_load(input logic [NBITS-1:0] w);
        req = 1'b1;
        cfg = w;
        #1 check("gnt", gnt, 1'b1);
        @(posedge clk);
        #1;
        check("mismatch_clr_at_gnt", mismatch, 1'b0);
        req = 1'b0;
        cfg = {$urandom, $urandom};
        clear_mon();
    endtask

    task automatic full_load(input logic [NBITS-1:0] w, input bit busy_req, input int corrupt_at);
        int cyc;
        logic exp_mm;
        exp_mm = (chain != last_word) || (corrupt_at >= 0);
`ifndef PADCTL_CFG_READBACK_EN
        exp_mm = 1'b0;
`endif
        start_load(w);
        cyc = 0;
        while (dones == 0 && cyc < LAT + 50) begin
            tick();
            cyc++;
            req  = 1'b0;
            flip = (corrupt_at >= 0 && rises == corrupt_at);
            if (busy_req && cyc == 100) begin
                req = 1'b1;
                cfg = ~w;
                #1 check("gnt_while_busy", gnt, 1'b0);
            end
        end
        flip = 1'b0;
        check("done_latency", cyc, LAT);
        check("sck_rises", rises, NBITS);
        check("sdo_word", rise_bits, w);
        check("latch_cycles", latch_cycles, DIV);
        check("sdo_stable", sdo_viol, 0);
        check("mismatch_at_done", mismatch, exp_mm);
        last_word = w;
        repeat (20) tick();
        check("single_done", dones, 1);
        check("idle_outputs", {busy, sck, sdo, latch}, 4'b0);
    endtask

    initial begin
        int cyc;
        clear_mon();
        #12;
        check("rst_outputs", {gnt, busy, done, aborted, sck, sdo, latch, mismatch}, 8'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed word with an ignored request mid-shift, then random words.
        full_load(64'hA5A5_0000_FFFF_1234, 1'b1, -1);
        for (int i = 0; i < 3; i++) full_load({$urandom, $urandom}, 1'b0, -1);

        // Abort in IDLE has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_idle", {aborted, busy}, 2'b0);

        // Abort while bit 20 is on the chain.
        start_load({$urandom, $urandom});
        cyc = 0;
        while (rises < NBITS - 20 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("abort_reached_bit20", rises, NBITS - 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("aborted_pulse", aborted, 1'b1);
        check("abort_lines_low", {busy, sck, sdo, latch}, 4'b0);
        repeat (30) tick();
        check("abort_no_done", dones, 0);
        check("abort_no_latch", latch_cycles, 0);
        check("abort_single_pulse", aborts, 1);
        full_load({$urandom, $urandom}, 1'b0, -1);

        // Asynchronous reset in the middle of LATCH.
        start_load({$urandom, $urandom});
        cyc = 0;
        while (!latch && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("reached_latch", latch, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_async_drop", {latch, busy, sck}, 3'b0);
        @(negedge clk);
        rst = 1'b0;
        last_word = '0;
        tick();
        check("post_rst_done", dones, 0);
        full_load({$urandom, $urandom}, 1'b0, -1);

        // Readback: two clean loads, one with a corrupted returned bit, then a clean one.
        full_load({$urandom, $urandom}, 1'b0, -1);
        full_load({$urandom, $urandom}, 1'b0, -1);
        full_load({$urandom, $urandom}, 1'b0, 10);
        full_load({$urandom, $urandom}, 1'b0, -1);

        // Minimal chain: NumPads=2, AttrW=2, ClkDiv=1.
        req_s = 1'b1;
        cfg_s = 4'b1011;
        #1 check("small_gnt", gnt_s, 1'b1);
        @(posedge clk);
        #1 req_s = 1'b0;
        rises_s = 0; dones_s = 0; viol_s = 0; shift_s = 0; bits_s = '0;
        cyc = 0;
        while (dones_s == 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("small_latency", cyc, SLAT);
        check("small_sdo_seq", bits_s, 4'b1011);
        check("small_rises", rises_s, 4);
        check("small_sck_toggle", viol_s, 0);
        check("small_mismatch", mismatch_s, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
